// File: rtl/i2c_txn_sequencer_if.sv
// Request/response handshake and i2c-master command bundle for i2c_txn_sequencer.
// slave: the sequencer itself; master: the request source plus the i2c master it drives.
interface i2c_txn_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       rsp_timeout;
  logic [3:0] m_cmd;
  logic       m_write;
  logic [7:0] m_wdata;
  logic       m_ready;
  logic [7:0] m_rdata;
  logic       m_nack;

  modport slave (
    input  req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata,
    input  m_ready, m_rdata, m_nack,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
    output m_cmd, m_write, m_wdata
  );

  modport master (
    output req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata,
    output m_ready, m_rdata, m_nack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
    input  m_cmd, m_write, m_wdata
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Turns one register read/write request into the i2c master's START/WRITE/RESTART/READ/STOP stream.
// Optional stall watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_txn_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_txn_sequencer_if.slave   bus
);

  // Command encodings shared with the i2c master
  localparam logic [3:0] K_START_CMD   = 4'd1;
  localparam logic [3:0] K_STOP_CMD    = 4'd2;
  localparam logic [3:0] K_WRITE_CMD   = 4'd3;
  localparam logic [3:0] K_READ_CMD    = 4'd4;
  localparam logic [3:0] K_RESTART_CMD = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [2:0] stop_step;

  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;

  logic       first_q;
  logic       nack_q;
  logic [7:0] rdata_q;

  logic [3:0] cmd_q;
  logic [7:0] cmd_data_q;
  logic [11:0] next_cmd;

  logic       rsp_nack_q;
  logic       rsp_timeout_q;
  logic [7:0] rsp_rdata_q;

  logic       accept;
  logic       strobe;
  logic       load_cmd;
  logic       set_nack;
  logic       capture_rdata;
  logic       finish;
  logic       timeout_hit;

  // {command, byte} for a given step of the write or read sequence
  function automatic logic [11:0] step_cmd(input logic [2:0] step, input logic rw,
                                           input logic [6:0] dev, input logic [7:0] reg_addr,
                                           input logic [7:0] wd);
    logic [11:0] c;
    case (step)
      3'd0:    c = {K_START_CMD, 8'h00};
      3'd1:    c = {K_WRITE_CMD, dev, 1'b0};
      3'd2:    c = {K_WRITE_CMD, reg_addr};
      3'd3:    c = rw ? {K_RESTART_CMD, 8'h00} : {K_WRITE_CMD, wd};
      3'd4:    c = rw ? {K_WRITE_CMD, dev, 1'b1} : {K_STOP_CMD, 8'h00};
      3'd5:    c = {K_READ_CMD, 8'h00};
      default: c = {K_STOP_CMD, 8'h00};
    endcase
    return c;
  endfunction

  assign stop_step = rw_q ? 3'd6 : 3'd4;
  assign next_cmd  = step_cmd(step_d, rw_q, dev_q, reg_q, wdata_q);

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (strobe) begin
      timer_q <= '0;
    end else if (state_q == WAIT && !bus.m_ready) begin
      timer_q <= timer_q + 16'd1;
    end
  end

  // Fires on the cycle whose stalled edge would make the count reach TIMEOUT_CYCLES
  assign timeout_hit = (state_q == WAIT) && !bus.m_ready && (timer_q == TIMEOUT_CYCLES - 16'd1);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    accept        = 1'b0;
    strobe        = 1'b0;
    load_cmd      = 1'b0;
    set_nack      = 1'b0;
    capture_rdata = 1'b0;
    finish        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          step_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          strobe  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (timeout_hit) begin
          finish  = 1'b1;
          state_d = DONE;
        end else if (!first_q && bus.m_ready) begin
          if (step_q == stop_step) begin
            finish  = 1'b1;
            state_d = DONE;
          end else if (cmd_q == K_WRITE_CMD && bus.m_nack) begin
            set_nack = 1'b1;
            step_d   = stop_step;
            load_cmd = 1'b1;
            state_d  = ISSUE;
          end else begin
            capture_rdata = (cmd_q == K_READ_CMD);
            step_d        = 3'(step_q + 3'd1);
            load_cmd      = 1'b1;
            state_d       = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The first command is loaded at acceptance so the strobe can go out the very next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q          <= 1'b0;
      dev_q         <= '0;
      reg_q         <= '0;
      wdata_q       <= '0;
      first_q       <= 1'b0;
      nack_q        <= 1'b0;
      rdata_q       <= '0;
      cmd_q         <= '0;
      cmd_data_q    <= '0;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      if (accept) begin
        rw_q       <= bus.req_rw;
        dev_q      <= bus.req_dev_addr;
        reg_q      <= bus.req_reg_addr;
        wdata_q    <= bus.req_wdata;
        nack_q     <= 1'b0;
        rdata_q    <= '0;
        cmd_q      <= K_START_CMD;
        cmd_data_q <= '0;
      end
      if (strobe) begin
        first_q <= 1'b1;
      end else if (state_q == WAIT) begin
        first_q <= 1'b0;
      end
      if (load_cmd) begin
        cmd_q      <= next_cmd[11:8];
        cmd_data_q <= next_cmd[7:0];
      end
      if (set_nack) begin
        nack_q <= 1'b1;
      end
      if (capture_rdata) begin
        rdata_q <= bus.m_rdata;
      end
      if (finish) begin
        rsp_timeout_q <= timeout_hit;
        rsp_nack_q    <= nack_q & ~timeout_hit;
        rsp_rdata_q   <= (nack_q || timeout_hit) ? 8'h00 : rdata_q;
      end
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == DONE);
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_nack    = rsp_nack_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.m_write     = strobe;
  assign bus.m_cmd       = cmd_q;
  assign bus.m_wdata     = cmd_data_q;

endmodule
